// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl -- HD44780 character-LCD controller (8-bit bus, write only).
//
// Holds a ROWS x COLS character buffer written by the host. After reset it
// waits for the panel to power up, runs the init sequence (0x38, 0x0C, 0x06,
// 0x01), then refreshes every row from the buffer forever. Between frames a
// one-tick gap lets one host instruction byte in through cmd_valid/cmd_ready.
// Every LCD byte takes three step ticks: setup, enable high, enable low.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data buffer write port (index = row*COLS+col)
//   cmd_valid/cmd_data    host instruction request; cmd_ready high in the gap
//   busy                  high until the init sequence has completed
//   frame_done            one-clk pulse after the last character of a frame
//   lcd_rs/lcd_rw/lcd_en/lcd_data  HD44780 bus (lcd_rw tied low)
//   LCD_N/LCD_P           backlight supply pins
//
// Optional feature: define LCD_BACKLIGHT_PWM_EN to add input bl_level[7:0]
// and drive LCD_P from an 8-bit PWM; otherwise LCD_P is constant 1.
module lcd_hd44780_ctrl #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int TICK_DIV    = 2500,
  parameter int PWRUP_TICKS = 400,
  parameter int CLEAR_TICKS = 40,
  parameter int AW          = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_data,
`ifdef LCD_BACKLIGHT_PWM_EN
  input  logic [7:0]    bl_level,
`endif
  output logic          cmd_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_data,
  output logic          LCD_N,
  output logic          LCD_P
);

  localparam int DEPTH = ROWS * COLS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW    = $clog2(TICK_DIV);
  localparam int WMAX  = (PWRUP_TICKS > CLEAR_TICKS) ? PWRUP_TICKS : CLEAR_TICKS;
  localparam int WW    = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    PWRUP, INIT, ROW_ADDR, ROW_DATA, GAP, CMD, WAIT
  } state_t;

  state_t          state, state_n;
  logic [1:0]      phase, phase_n;        // position inside a 3-tick byte transfer
  logic [WW-1:0]   wait_cnt, wait_cnt_n;
  logic [WW-1:0]   wait_len, wait_len_n;
  logic [1:0]      init_idx, init_idx_n;
  logic            row, row_n;
  logic [CW-1:0]   col, col_n;
  logic [7:0]      cmd_byte, cmd_byte_n;
  logic            rs_n, en_n, busy_n, frame_done_n;
  logic [7:0]      data_n;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [7:0]      buf_mem [DEPTH];
  logic [AW-1:0]   rd_addr;
  logic            tx_rs;
  logic [7:0]      tx_byte;

  assign lcd_rw    = 1'b0;
  assign LCD_N     = 1'b0;
  assign cmd_ready = (state == GAP);

  // Step tick: fires on the TICK_DIV-th clk after reset release, then every TICK_DIV.
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // NOTE: the buffer must come up as spaces, so it is a reset register array rather than a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= 8'h20;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      buf_mem[wr_addr] <= wr_data;
    end
  end

  // A write on the same edge as the read lands after the old value is captured.
  assign rd_addr = AW'(int'(row) * COLS + int'(col));

  // Byte the current state would put on the bus.
  always_comb begin
    tx_rs   = 1'b0;
    tx_byte = cmd_byte;
    case (state)
      INIT: begin
        case (init_idx)
          2'd0:    tx_byte = 8'h38;
          2'd1:    tx_byte = 8'h0C;
          2'd2:    tx_byte = 8'h06;
          default: tx_byte = 8'h01;
        endcase
      end
      ROW_ADDR: tx_byte = row ? 8'hC0 : 8'h80;
      ROW_DATA: begin
        tx_rs   = 1'b1;
        tx_byte = buf_mem[rd_addr];
      end
      default: ;
    endcase
  end

  // NOTE: every next-state value is defaulted to its current value first, so no latches appear.
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    wait_cnt_n   = wait_cnt;
    wait_len_n   = wait_len;
    init_idx_n   = init_idx;
    row_n        = row;
    col_n        = col;
    cmd_byte_n   = cmd_byte;
    rs_n         = lcd_rs;
    data_n       = lcd_data;
    en_n         = lcd_en;
    busy_n       = busy;
    frame_done_n = 1'b0;

    if (state == GAP && cmd_valid) begin
      // Accept on this edge regardless of tick so cmd_ready drops next cycle.
      cmd_byte_n = cmd_data;
      state_n    = CMD;
      phase_n    = 2'd0;
    end else if (tick) begin
      case (state)
        PWRUP: begin
          if (wait_cnt == WW'(PWRUP_TICKS - 1)) begin
            state_n    = INIT;
            wait_cnt_n = '0;
            init_idx_n = 2'd0;
          end else begin
            wait_cnt_n = wait_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == wait_len - 1'b1) begin
            state_n    = ROW_ADDR;
            row_n      = 1'b0;
            wait_cnt_n = '0;
            busy_n     = 1'b0;
          end else begin
            wait_cnt_n = wait_cnt + 1'b1;
          end
        end
        GAP: begin
          state_n = ROW_ADDR;
          row_n   = 1'b0;
        end
        default: begin
          case (phase)
            2'd0: begin
              rs_n    = tx_rs;
              data_n  = tx_byte;
              en_n    = 1'b0;
              phase_n = 2'd1;
            end
            2'd1: begin
              en_n    = 1'b1;
              phase_n = 2'd2;
            end
            default: begin
              en_n    = 1'b0;
              phase_n = 2'd0;
              case (state)
                INIT: begin
                  if (init_idx == 2'd3) begin
                    state_n    = WAIT;
                    wait_len_n = WW'(CLEAR_TICKS);
                    wait_cnt_n = '0;
                  end else begin
                    init_idx_n = init_idx + 1'b1;
                  end
                end
                ROW_ADDR: begin
                  state_n = ROW_DATA;
                  col_n   = '0;
                end
                ROW_DATA: begin
                  if (col == CW'(COLS - 1)) begin
                    col_n = '0;
                    if (row == 1'(ROWS - 1)) begin
                      frame_done_n = 1'b1;
                      state_n      = GAP;
                    end else begin
                      row_n   = row + 1'b1;
                      state_n = ROW_ADDR;
                    end
                  end else begin
                    col_n = col + 1'b1;
                  end
                end
                default: begin  // CMD: clear/home need the long settle time
                  state_n    = WAIT;
                  wait_cnt_n = '0;
                  wait_len_n = (cmd_byte == 8'h01 || cmd_byte == 8'h02)
                             ? WW'(CLEAR_TICKS) : WW'(1);
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PWRUP;
      phase      <= 2'd0;
      wait_cnt   <= '0;
      wait_len   <= '0;
      init_idx   <= 2'd0;
      row        <= 1'b0;
      col        <= '0;
      cmd_byte   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_en     <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      wait_cnt   <= wait_cnt_n;
      wait_len   <= wait_len_n;
      init_idx   <= init_idx_n;
      row        <= row_n;
      col        <= col_n;
      cmd_byte   <= cmd_byte_n;
      lcd_rs     <= rs_n;
      lcd_data   <= data_n;
      lcd_en     <= en_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

`ifdef LCD_BACKLIGHT_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= 8'h00;
      LCD_P   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LCD_P   <= (pwm_cnt < bl_level);
    end
  end
`else
  assign LCD_P = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed self-checking bench for lcd_hd44780_ctrl with a small 2x10 display
// and short timing (TICK_DIV=4, PWRUP_TICKS=5, CLEAR_TICKS=3).
module tb_lcd_hd44780_ctrl;

  localparam int TD = 4;
  localparam int PT = 5;
  localparam int CT = 3;
  localparam int NC = 10;
  localparam int NR = 2;
  localparam int AW = 5;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
    logic       busy;
  } ev_t;

  typedef logic [7:0] frame_t [NR*NC];

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          cmd_ready, busy, frame_done;
  logic          lcd_rs, lcd_rw, lcd_en;
  logic [7:0]    lcd_data;
  logic          LCD_N, LCD_P;
`ifdef LCD_BACKLIGHT_PWM_EN
  logic [7:0]    bl_level = 8'd0;
`endif

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .COLS(NC), .ROWS(NR), .TICK_DIV(TD), .PWRUP_TICKS(PT), .CLEAR_TICKS(CT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data),
`ifdef LCD_BACKLIGHT_PWM_EN
    .bl_level(bl_level),
`endif
    .cmd_ready(cmd_ready), .busy(busy), .frame_done(frame_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .LCD_N(LCD_N), .LCD_P(LCD_P)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: records every enable rising edge with the byte it strobes.
  int   cyc;
  ev_t  q[$];
  logic en_d = 1'b0;
  logic fd_d = 1'b0;
  logic [8:0] bus_d = '0;
  int   fd_pulses = 0, fd_high = 0, rdy_cycles = 0, en_viol = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (lcd_en && !en_d) q.push_back('{lcd_rs, lcd_data, cyc, busy});
    if (lcd_en && en_d && ({lcd_rs, lcd_data} != bus_d)) en_viol <= en_viol + 1;
    if (frame_done) fd_high <= fd_high + 1;
    if (frame_done && !fd_d) fd_pulses <= fd_pulses + 1;
    if (cmd_ready) rdy_cycles <= rdy_cycles + 1;
    en_d  <= lcd_en;
    fd_d  <= frame_done;
    bus_d <= {lcd_rs, lcd_data};
  end

  int last_cyc = 0;

  task automatic get_ev(output ev_t e);
    int n = 0;
    while (q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      check("byte_timeout", 1, 0);
      e = '{1'b0, 8'h00, last_cyc, 1'b0};
    end else begin
      e = q.pop_front();
    end
  endtask

  // gap_exp != 0 also checks the clk distance from the previous strobe.
  task automatic expect_byte(input string tag, input logic rs, input logic [7:0] d,
                             input int gap_exp);
    ev_t e;
    get_ev(e);
    check(tag, {23'd0, e.rs, e.data}, {23'd0, rs, d});
    if (gap_exp != 0) check({tag, "_gap"}, e.cyc - last_cyc, gap_exp);
    last_cyc = e.cyc;
  endtask

  // Full init after a reset release; cyc is 0 at the release edge.
  task automatic expect_init(input string tag);
    ev_t e;
    get_ev(e);
    check({tag, "_first_en_cyc"}, e.cyc, TD * (PT + 2));
    check({tag, "_0x38"}, {e.rs, e.data}, {1'b0, 8'h38});
    check({tag, "_busy"}, e.busy, 1'b1);
    last_cyc = e.cyc;
    expect_byte({tag, "_0x0C"}, 1'b0, 8'h0C, 3 * TD);
    expect_byte({tag, "_0x06"}, 1'b0, 8'h06, 3 * TD);
    get_ev(e);
    check({tag, "_0x01"}, {e.rs, e.data}, {1'b0, 8'h01});
    check({tag, "_busy_at_clear"}, e.busy, 1'b1);
    last_cyc = e.cyc;
    get_ev(e);
    check({tag, "_row0_addr"}, {e.rs, e.data}, {1'b0, 8'h80});
    check({tag, "_clear_gap"}, e.cyc - last_cyc, (CT + 3) * TD);
    check({tag, "_busy_done"}, e.busy, 1'b0);
    last_cyc = e.cyc;
  endtask

  // Frame body; the row-0 address strobe is consumed here only when first_addr=1.
  task automatic expect_frame(input string tag, input frame_t m, input logic first_addr,
                              input int gap_exp);
    for (int r = 0; r < NR; r++) begin
      if (r > 0 || first_addr)
        expect_byte({tag, "_addr"}, 1'b0, (r == 0) ? 8'h80 : 8'hC0,
                    (r == 0) ? gap_exp : 0);
      for (int c = 0; c < NC; c++)
        expect_byte({tag, "_char"}, 1'b1, m[r*NC + c], 0);
    end
  endtask

  task automatic write(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  frame_t exp_frame, blank;
  int     rdy0, n;
  logic   exp_lcd_p;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
    cmd_valid = 1'b0; cmd_data = 8'h00;
`ifdef LCD_BACKLIGHT_PWM_EN
    exp_lcd_p = 1'b0;
`else
    exp_lcd_p = 1'b1;
`endif
    for (int i = 0; i < NR*NC; i++) blank[i] = 8'h20;
    exp_frame = blank;
    exp_frame[0] = "H"; exp_frame[1] = "E"; exp_frame[2] = "L";
    exp_frame[3] = "L"; exp_frame[4] = "O"; exp_frame[NR*NC-1] = "X";

    repeat (3) @(negedge clk);
    check("rst_bus", {lcd_en, lcd_rs, lcd_data}, 10'h000);
    check("rst_busy", busy, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("lcd_rw", lcd_rw, 1'b0);
    check("lcd_n", LCD_N, 1'b0);
    check("lcd_p_rst", LCD_P, exp_lcd_p);

    @(negedge clk);
    rst = 1'b0;
    // Writes during busy, plus two out-of-range writes that must be ignored.
    write(0, "H"); write(1, "E"); write(2, "L"); write(3, "L"); write(4, "O");
    write(NR*NC-1, "X");
    write(NR*NC, "Z");
    write(31, "Q");

    expect_init("init1");
    expect_frame("frame1", exp_frame, 1'b0, 0);
    repeat (2 * TD) @(negedge clk);
    check("fd_after_frame1", fd_pulses, 1);

    // Command request raised mid-frame; must wait for the gap and be taken once.
    fork
      expect_frame("frame2", exp_frame, 1'b1, 0);
      begin
        repeat (40) @(negedge clk);
        check("ready_mid_frame", cmd_ready, 1'b0);
        rdy0      = rdy_cycles;
        cmd_valid = 1'b1;
        cmd_data  = 8'h01;
      end
    join
    expect_byte("cmd_0x01", 1'b0, 8'h01, 0);
    cmd_valid = 1'b0;
    check("ready_cycles", rdy_cycles - rdy0, 1);
    expect_frame("frame3", exp_frame, 1'b1, (CT + 3) * TD);
    repeat (2 * TD) @(negedge clk);
    check("fd_after_frame3", fd_pulses, 3);
    check("fd_width", fd_high, fd_pulses);

    // Reset while the enable strobe is high.
    n = 0;
    while (!lcd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("en_seen", lcd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_en", lcd_en, 1'b0);
    check("rst_async_outs", {lcd_rs, lcd_data, busy, cmd_ready, frame_done},
          {1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
    check("lcd_p_async_rst", LCD_P, exp_lcd_p);
    q.delete();
    repeat (2) @(negedge clk);
    q.delete();
    rst = 1'b0;
    expect_init("init2");
    expect_frame("frame_blank", blank, 1'b0, 0);
    check("en_stable", en_viol, 0);

`ifdef LCD_BACKLIGHT_PWM_EN
    bl_level = 8'd64;
    repeat (4) @(negedge clk);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (LCD_P) n++;
    end
    check("pwm_64", n, 64);
    bl_level = 8'd0;
    repeat (4) @(negedge clk);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (LCD_P) n++;
    end
    check("pwm_0", n, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
